// File: rtl/unit_propagate_if.sv
// -----------------------------------------------------------------------------
// unit_propagate_if
// Bundles the request/result signals of the unit_propagate stage.
// A formula is carried flattened as three fields:
//   *_len   number of valid clauses
//   *_clen  per-clause literal count
//   *_lits  per-clause literal slots, lit = {neg, var[VAR_W-1:0]}
// Signals:
//   start          request, sampled by the stage only while idle
//   in_len/in_clen/in_lits  formula to rewrite
//   in_lit         unit literal L
//   ended          one-cycle result-valid pulse
//   conflict       a clause became empty (valid with ended)
//   empty_formula  no clauses remain (valid with ended)
//   out_len/out_clen/out_lits  rewritten formula
//   clauses_removed/lits_removed  statistics (UNIT_PROPAGATE_STATS_EN only)
// Modports: master (controller side), slave (unit_propagate side).
// -----------------------------------------------------------------------------
interface unit_propagate_if #(
    parameter int NUMBER_CLAUSES = 16,
    parameter int MAX_LITS       = 8,
    parameter int VAR_W          = 6
);
    localparam int LIT_W  = VAR_W + 1;
    localparam int CLEN_W = $clog2(MAX_LITS + 1);
    localparam int FLEN_W = $clog2(NUMBER_CLAUSES + 1);
    localparam int LR_W   = $clog2(NUMBER_CLAUSES * MAX_LITS + 1);

    logic                                             start;
    logic [FLEN_W-1:0]                                in_len;
    logic [NUMBER_CLAUSES-1:0][CLEN_W-1:0]            in_clen;
    logic [NUMBER_CLAUSES-1:0][MAX_LITS-1:0][LIT_W-1:0] in_lits;
    logic [LIT_W-1:0]                                 in_lit;

    logic                                             ended;
    logic                                             conflict;
    logic                                             empty_formula;
    logic [FLEN_W-1:0]                                out_len;
    logic [NUMBER_CLAUSES-1:0][CLEN_W-1:0]            out_clen;
    logic [NUMBER_CLAUSES-1:0][MAX_LITS-1:0][LIT_W-1:0] out_lits;
`ifdef UNIT_PROPAGATE_STATS_EN
    logic [FLEN_W-1:0]                                clauses_removed;
    logic [LR_W-1:0]                                  lits_removed;
`endif

    modport master (
        output start, in_len, in_clen, in_lits, in_lit,
        input  ended, conflict, empty_formula, out_len, out_clen, out_lits
`ifdef UNIT_PROPAGATE_STATS_EN
        , input clauses_removed, lits_removed
`endif
    );

    modport slave (
        input  start, in_len, in_clen, in_lits, in_lit,
        output ended, conflict, empty_formula, out_len, out_clen, out_lits
`ifdef UNIT_PROPAGATE_STATS_EN
        , output clauses_removed, lits_removed
`endif
    );
endinterface

// File: rtl/unit_propagate.sv
// -----------------------------------------------------------------------------
// unit_propagate
// DPLL stage following the unit-clause finder. Given a formula and a unit
// literal L, it drops every clause containing L and deletes ~L from the
// remaining clauses, compacting the survivors. One clause is examined per
// clock; the controller is told about a conflict (a clause emptied) or an
// empty formula (all clauses satisfied).
// Ports:
//   clock   rising-edge clock
//   reset   synchronous, active-high
//   bus     unit_propagate_if.slave (request, formula in, result, formula out)
// Optional feature: define UNIT_PROPAGATE_STATS_EN to add the
// clauses_removed / lits_removed counters on the interface.
// -----------------------------------------------------------------------------
module unit_propagate #(
    parameter int NUMBER_CLAUSES = 16,
    parameter int MAX_LITS       = 8,
    parameter int VAR_W          = 6
) (
    input  logic          clock,
    input  logic          reset,
    unit_propagate_if.slave bus
);
    localparam int LIT_W  = VAR_W + 1;
    localparam int CLEN_W = $clog2(MAX_LITS + 1);
    localparam int FLEN_W = $clog2(NUMBER_CLAUSES + 1);
    localparam int IDX_W  = (NUMBER_CLAUSES > 1) ? $clog2(NUMBER_CLAUSES) : 1;
    localparam int SLOT_W = (MAX_LITS > 1) ? $clog2(MAX_LITS) : 1;
`ifdef UNIT_PROPAGATE_STATS_EN
    localparam int LR_W   = $clog2(NUMBER_CLAUSES * MAX_LITS + 1);
`endif

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t r_state;
    state_t w_next_state;

    // Latched request
    logic [NUMBER_CLAUSES-1:0][MAX_LITS-1:0][LIT_W-1:0] r_lits;
    logic [NUMBER_CLAUSES-1:0][CLEN_W-1:0]              r_clen;
    logic [FLEN_W-1:0]                                  r_len;
    logic [LIT_W-1:0]                                   r_lit;

    // Scan pointers: r_i reads, r_o writes; r_o never passes r_i
    logic [FLEN_W-1:0] r_i;
    logic [FLEN_W-1:0] r_o;

    // Results
    logic                                               r_ended;
    logic                                               r_conflict;
    logic                                               r_empty;
    logic [FLEN_W-1:0]                                  r_out_len;
    logic [NUMBER_CLAUSES-1:0][CLEN_W-1:0]              r_out_clen;
    logic [NUMBER_CLAUSES-1:0][MAX_LITS-1:0][LIT_W-1:0] r_out_lits;
`ifdef UNIT_PROPAGATE_STATS_EN
    logic [FLEN_W-1:0]                                  r_clauses_removed;
    logic [LR_W-1:0]                                    r_lits_removed;
`endif

    // Evaluation of the current clause
    logic [LIT_W-1:0]                  w_neg_lit;
    logic [CLEN_W-1:0]                 w_cur_clen;
    logic [MAX_LITS-1:0][LIT_W-1:0]    w_cur_lits;
    logic [MAX_LITS-1:0][LIT_W-1:0]    w_pack;
    logic [CLEN_W-1:0]                 w_plen;
    logic [CLEN_W-1:0]                 w_nrem;
    logic                              w_sat;
    logic                              w_scan_done;
    logic                              w_hit_conflict;
    logic [FLEN_W-1:0]                 w_len_clamped;

    assign w_neg_lit  = {~r_lit[VAR_W], r_lit[VAR_W-1:0]};
    assign w_cur_clen = r_clen[r_i[IDX_W-1:0]];
    assign w_cur_lits = r_lits[r_i[IDX_W-1:0]];

    assign w_len_clamped = (bus.in_len > FLEN_W'(NUMBER_CLAUSES)) ?
                           FLEN_W'(NUMBER_CLAUSES) : bus.in_len;

    // Satisfaction is detected over the whole clause, so a clause holding
    // both L and ~L is dropped regardless of slot order; the packed copy is
    // simply discarded in that case.
    always_comb begin
        w_pack = '0;
        w_plen = '0;
        w_nrem = '0;
        w_sat  = 1'b0;
        for (int j = 0; j < MAX_LITS; j++) begin
            if (CLEN_W'(j) < w_cur_clen) begin
                if (w_cur_lits[j] == r_lit) begin
                    w_sat = 1'b1;
                end else if (w_cur_lits[j] == w_neg_lit) begin
                    w_nrem = w_nrem + CLEN_W'(1);
                end else begin
                    w_pack[w_plen[SLOT_W-1:0]] = w_cur_lits[j];
                    w_plen = w_plen + CLEN_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_scan_done    = 1'b0;
        w_hit_conflict = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_i == r_len) begin
                    w_scan_done  = 1'b1;
                    w_next_state = S_IDLE;
                end else if (!w_sat && (w_plen == '0)) begin
                    w_hit_conflict = 1'b1;
                    w_next_state   = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture needs no reset: it is only read while scanning, and
    // scanning is always preceded by a capture.
    always_ff @(posedge clock) begin
        if ((r_state == S_IDLE) && bus.start) begin
            r_lits <= bus.in_lits;
            r_clen <= bus.in_clen;
            r_len  <= w_len_clamped;
            r_lit  <= bus.in_lit;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_i               <= '0;
            r_o               <= '0;
            r_ended           <= 1'b0;
            r_conflict        <= 1'b0;
            r_empty           <= 1'b0;
            r_out_len         <= '0;
            r_out_clen        <= '0;
            r_out_lits        <= '0;
`ifdef UNIT_PROPAGATE_STATS_EN
            r_clauses_removed <= '0;
            r_lits_removed    <= '0;
`endif
        end else begin
            r_ended <= 1'b0;
            if (r_state == S_IDLE) begin
                if (bus.start) begin
                    r_i               <= '0;
                    r_o               <= '0;
                    r_conflict        <= 1'b0;
                    r_empty           <= 1'b0;
                    r_out_len         <= '0;
                    r_out_clen        <= '0;
                    r_out_lits        <= '0;
`ifdef UNIT_PROPAGATE_STATS_EN
                    r_clauses_removed <= '0;
                    r_lits_removed    <= '0;
`endif
                end
            end else if (w_scan_done) begin
                r_ended   <= 1'b1;
                r_out_len <= r_o;
                r_empty   <= (r_o == '0);
            end else begin
                r_i <= r_i + FLEN_W'(1);
`ifdef UNIT_PROPAGATE_STATS_EN
                if (w_sat) begin
                    r_clauses_removed <= r_clauses_removed + FLEN_W'(1);
                end else begin
                    r_lits_removed <= r_lits_removed + LR_W'(w_nrem);
                end
`endif
                if (w_hit_conflict) begin
                    // Empty clause is not written; the count stops at r_o.
                    r_ended    <= 1'b1;
                    r_conflict <= 1'b1;
                    r_out_len  <= r_o;
                end else if (!w_sat) begin
                    r_out_clen[r_o[IDX_W-1:0]] <= w_plen;
                    r_out_lits[r_o[IDX_W-1:0]] <= w_pack;
                    r_o <= r_o + FLEN_W'(1);
                end
            end
        end
    end

    assign bus.ended         = r_ended;
    assign bus.conflict      = r_conflict;
    assign bus.empty_formula = r_empty;
    assign bus.out_len       = r_out_len;
    assign bus.out_clen      = r_out_clen;
    assign bus.out_lits      = r_out_lits;
`ifdef UNIT_PROPAGATE_STATS_EN
    assign bus.clauses_removed = r_clauses_removed;
    assign bus.lits_removed    = r_lits_removed;
`endif

endmodule

// File: tb/tb_unit_propagate.sv
// -----------------------------------------------------------------------------
// tb_unit_propagate
// Directed, table-driven bench for unit_propagate with default parameters
// (16 clauses, 8 literal slots, 6-bit variables). Table records hold up to
// four clauses of four literals; everything beyond is zero.
// -----------------------------------------------------------------------------
module tb_unit_propagate;

    logic clk;
    logic rst;

    unit_propagate_if bus ();

    unit_propagate dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]             len;
        logic [3:0][3:0]        clen;
        logic [3:0][3:0][6:0]   lits;
        logic [6:0]             lit;
        logic [5:0]             e_lat;
        logic                   e_conf;
        logic                   e_empty;
        logic [4:0]             e_olen;
        logic [3:0][3:0]        e_clen;
        logic [3:0][3:0][6:0]   e_lits;
    } vec_t;

    localparam int NV = 7;
    vec_t tv [NV];

    int errors = 0;
    int checks = 0;

    function automatic logic [6:0] P(input int v);
        return {1'b0, 6'(v)};
    endfunction

    function automatic logic [6:0] N(input int v);
        return {1'b1, 6'(v)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        bus.in_len  = v.len;
        bus.in_clen = '0;
        bus.in_lits = '0;
        bus.in_lit  = v.lit;
        for (int c = 0; c < 4; c++) begin
            bus.in_clen[c] = v.clen[c];
            for (int s = 0; s < 4; s++) bus.in_lits[c][s] = v.lits[c][s];
        end
    endtask

    // Pulses start for one edge, then waits (bounded) for ended.
    // lat = number of edges after the accepting edge, -1 on timeout.
    task automatic run_wait(output int lat);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.ended) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v, input int lat);
        chk({tag, ".latency"}, lat, 32'(v.e_lat));
        chk({tag, ".conflict"}, 32'(bus.conflict), 32'(v.e_conf));
        chk({tag, ".empty"}, 32'(bus.empty_formula), 32'(v.e_empty));
        chk({tag, ".out_len"}, 32'(bus.out_len), 32'(v.e_olen));
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s.clen%0d", tag, c), 32'(bus.out_clen[c]), 32'(v.e_clen[c]));
            for (int s = 0; s < 4; s++)
                chk($sformatf("%s.lit%0d_%0d", tag, c, s),
                    32'(bus.out_lits[c][s]), 32'(v.e_lits[c][s]));
        end
        chk({tag, ".clen4"}, 32'(bus.out_clen[4]), 32'd0);
    endtask

    task automatic after_pulse(input string tag, input vec_t v);
        @(posedge clk); #1;
        chk({tag, ".ended_width"}, 32'(bus.ended), 32'd0);
        chk({tag, ".hold_len"}, 32'(bus.out_len), 32'(v.e_olen));
        chk({tag, ".hold_conf"}, 32'(bus.conflict), 32'(v.e_conf));
    endtask

    initial begin
        int lat;
        int pulses;
        int first;
        vec_t clampv;

        // 0: L=+1, {(+1,+2),(-1,+3),(+4)} -> {(+3),(+4)}
        tv[0] = '0;
        tv[0].len = 5'd3; tv[0].lit = P(1);
        tv[0].clen[0] = 4'd2; tv[0].lits[0][0] = P(1); tv[0].lits[0][1] = P(2);
        tv[0].clen[1] = 4'd2; tv[0].lits[1][0] = N(1); tv[0].lits[1][1] = P(3);
        tv[0].clen[2] = 4'd1; tv[0].lits[2][0] = P(4);
        tv[0].e_lat = 6'd4; tv[0].e_olen = 5'd2;
        tv[0].e_clen[0] = 4'd1; tv[0].e_lits[0][0] = P(3);
        tv[0].e_clen[1] = 4'd1; tv[0].e_lits[1][0] = P(4);
        // 1: L=+2, {(-2),(+3)} -> conflict on first clause
        tv[1] = '0;
        tv[1].len = 5'd2; tv[1].lit = P(2);
        tv[1].clen[0] = 4'd1; tv[1].lits[0][0] = N(2);
        tv[1].clen[1] = 4'd1; tv[1].lits[1][0] = P(3);
        tv[1].e_lat = 6'd1; tv[1].e_conf = 1'b1;
        // 2: L=-5, {(-5,+6),(+5,-5)} -> both satisfied, empty formula
        tv[2] = '0;
        tv[2].len = 5'd2; tv[2].lit = N(5);
        tv[2].clen[0] = 4'd2; tv[2].lits[0][0] = N(5); tv[2].lits[0][1] = P(6);
        tv[2].clen[1] = 4'd2; tv[2].lits[1][0] = P(5); tv[2].lits[1][1] = N(5);
        tv[2].e_lat = 6'd3; tv[2].e_empty = 1'b1;
        // 3: len=0
        tv[3] = '0;
        tv[3].lit = P(9);
        tv[3].e_lat = 6'd1; tv[3].e_empty = 1'b1;
        // 4: L=+3, {(+1,-3),(+3),(-3,-3)} -> conflict at clause 2, one survivor
        tv[4] = '0;
        tv[4].len = 5'd3; tv[4].lit = P(3);
        tv[4].clen[0] = 4'd2; tv[4].lits[0][0] = P(1); tv[4].lits[0][1] = N(3);
        tv[4].clen[1] = 4'd1; tv[4].lits[1][0] = P(3);
        tv[4].clen[2] = 4'd2; tv[4].lits[2][0] = N(3); tv[4].lits[2][1] = N(3);
        tv[4].e_lat = 6'd3; tv[4].e_conf = 1'b1; tv[4].e_olen = 5'd1;
        tv[4].e_clen[0] = 4'd1; tv[4].e_lits[0][0] = P(1);
        // 5: L=-2, {(+1,+2,+3,+2), clen=1 (+4,[-2 ignored])} -> {(+1,+3),(+4)}
        tv[5] = '0;
        tv[5].len = 5'd2; tv[5].lit = N(2);
        tv[5].clen[0] = 4'd4;
        tv[5].lits[0][0] = P(1); tv[5].lits[0][1] = P(2);
        tv[5].lits[0][2] = P(3); tv[5].lits[0][3] = P(2);
        tv[5].clen[1] = 4'd1; tv[5].lits[1][0] = P(4); tv[5].lits[1][1] = N(2);
        tv[5].e_lat = 6'd3; tv[5].e_olen = 5'd2;
        tv[5].e_clen[0] = 4'd2; tv[5].e_lits[0][0] = P(1); tv[5].e_lits[0][1] = P(3);
        tv[5].e_clen[1] = 4'd1; tv[5].e_lits[1][0] = P(4);
        // 6: L=+1, {(-1,-1,+7)} -> {(+7)}
        tv[6] = '0;
        tv[6].len = 5'd1; tv[6].lit = P(1);
        tv[6].clen[0] = 4'd3;
        tv[6].lits[0][0] = N(1); tv[6].lits[0][1] = N(1); tv[6].lits[0][2] = P(7);
        tv[6].e_lat = 6'd2; tv[6].e_olen = 5'd1;
        tv[6].e_clen[0] = 4'd1; tv[6].e_lits[0][0] = P(7);

        rst = 1'b1;
        bus.start = 1'b0;
        load(tv[3]);
        repeat (3) @(posedge clk);
        #1;
        chk("reset.ended", 32'(bus.ended), 32'd0);
        chk("reset.conflict", 32'(bus.conflict), 32'd0);
        chk("reset.empty", 32'(bus.empty_formula), 32'd0);
        chk("reset.out_len", 32'(bus.out_len), 32'd0);
        chk("reset.out_clen0", 32'(bus.out_clen[0]), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < NV - 1; v++) begin
            load(tv[v]);
            run_wait(lat);
            check_vec($sformatf("vec%0d", v), tv[v], lat);
`ifdef UNIT_PROPAGATE_STATS_EN
            if (v == 0) begin
                chk("vec0.clauses_removed", 32'(bus.clauses_removed), 32'd1);
                chk("vec0.lits_removed", 32'(bus.lits_removed), 32'd1);
            end
`endif
            after_pulse($sformatf("vec%0d", v), tv[v]);
        end

        // Back-to-back: new start in the ended cycle
        load(tv[3]);
        run_wait(lat);
        check_vec("b2b_a", tv[3], lat);
        load(tv[0]);
        run_wait(lat);
        check_vec("b2b_b", tv[0], lat);
        after_pulse("b2b_b", tv[0]);

        // Clause count above NUMBER_CLAUSES is clamped; all 16 slots survive
        clampv = '0;
        bus.in_len  = 5'd31;
        bus.in_lit  = P(40);
        bus.in_lits = '0;
        for (int c = 0; c < 16; c++) begin
            bus.in_clen[c] = 4'd1;
            bus.in_lits[c][0] = P(c + 1);
        end
        run_wait(lat);
        chk("clamp.latency", lat, 32'd17);
        chk("clamp.out_len", 32'(bus.out_len), 32'd16);
        chk("clamp.conflict", 32'(bus.conflict), 32'd0);
        chk("clamp.empty", 32'(bus.empty_formula), 32'd0);
        chk("clamp.clen15", 32'(bus.out_clen[15]), 32'd1);
        chk("clamp.lit15", 32'(bus.out_lits[15][0]), 32'(P(16)));
        @(posedge clk); #1;

        // start pulsed mid-scan is ignored: one ended pulse, test-0 results
        load(tv[0]);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        load(tv[1]);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        pulses = 0;
        first = -1;
        for (int n = 3; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus.ended) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
        chk("ignore.pulses", pulses, 32'd1);
        chk("ignore.latency", first, 32'd4);
        chk("ignore.out_len", 32'(bus.out_len), 32'd2);
        chk("ignore.conflict", 32'(bus.conflict), 32'd0);
        chk("ignore.lit0", 32'(bus.out_lits[0][0]), 32'(P(3)));

        // Reset during the second SCAN cycle aborts without a pulse
        load(tv[0]);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (bus.ended) pulses++;
        end
        chk("abort.pulses", pulses, 32'd0);
        chk("abort.conflict", 32'(bus.conflict), 32'd0);
        chk("abort.empty", 32'(bus.empty_formula), 32'd0);
        chk("abort.out_len", 32'(bus.out_len), 32'd0);
        chk("abort.out_clen0", 32'(bus.out_clen[0]), 32'd0);
        chk("abort.out_lit0", 32'(bus.out_lits[0][0]), 32'd0);

        load(tv[6]);
        run_wait(lat);
        check_vec("vec6", tv[6], lat);
        after_pulse("vec6", tv[6]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
